// File: rtl/tsp_result_display.sv
// Display sink for the TSP solver: converts a binary result to six BCD digits
// with a sequential double-dabble and drives active-low seven-segment digits and status LEDs.
module tsp_result_display #(
  parameter int unsigned W      = 20,
  parameter int unsigned DIGITS = 6
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [1:0]   SW,
  input  logic [W-1:0] in_value,
  input  logic         in_valid,
  output logic         in_ready,
  output logic [3:0]   LEDR,
  output logic [6:0]   HEX0,
  output logic [6:0]   HEX1,
  output logic [6:0]   HEX2,
  output logic [6:0]   HEX3,
  output logic [6:0]   HEX4,
  output logic [6:0]   HEX5
);

  localparam int unsigned       CW        = $clog2(W);
  localparam logic [CW-1:0]     LAST_BIT  = CW'(W - 1);
  localparam longint unsigned   MAX_SHOWN = 64'd999999;
  localparam logic [6:0]        SEG_BLANK = 7'h7F;
  localparam logic [6:0]        SEG_DASH  = 7'h3F;

  typedef enum logic [1:0] {IDLE, SHIFT, UPDATE} state_t;

  state_t              state;
  logic [W-1:0]        shreg;
  logic [4*DIGITS-1:0] bcd;
  logic [4*DIGITS-1:0] bcd_adj;
  logic [CW-1:0]       cnt;
  logic                ovf_pending;
  logic                ovf_q;
  logic                toggle_q;
  logic                hold_q;
  logic [6:0]          seg_q [DIGITS];
  logic [6:0]          seg_d [DIGITS];

  function automatic logic [6:0] seg7(input logic [3:0] d);
    case (d)
      4'd0:    seg7 = 7'h40;
      4'd1:    seg7 = 7'h79;
      4'd2:    seg7 = 7'h24;
      4'd3:    seg7 = 7'h30;
      4'd4:    seg7 = 7'h19;
      4'd5:    seg7 = 7'h12;
      4'd6:    seg7 = 7'h02;
      4'd7:    seg7 = 7'h78;
      4'd8:    seg7 = 7'h00;
      4'd9:    seg7 = 7'h10;
      default: seg7 = SEG_BLANK;
    endcase
  endfunction

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Walk from the top digit down; "lead" stays set until the first nonzero digit.
  // Digit 0 is never considered for blanking.
  always_comb begin
    logic        lead;
    int unsigned d;
    lead = 1'b1;
    d    = 0;
    for (int unsigned k = 0; k < DIGITS; k++) seg_d[k] = seg7(bcd[4*k +: 4]);
    for (int unsigned k = 1; k < DIGITS; k++) begin
      d = DIGITS - k;
      if (bcd[4*d +: 4] != 4'd0) lead = 1'b0;
      if (lead && SW[0]) seg_d[d] = SEG_BLANK;
    end
    if (ovf_pending) begin
      for (int unsigned k = 0; k < DIGITS; k++) seg_d[k] = SEG_DASH;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      shreg       <= '0;
      bcd         <= '0;
      cnt         <= '0;
      ovf_pending <= 1'b0;
      ovf_q       <= 1'b0;
      toggle_q    <= 1'b0;
      hold_q      <= 1'b0;
      for (int unsigned k = 0; k < DIGITS; k++) seg_q[k] <= SEG_BLANK;
    end else begin
      hold_q <= SW[1];
      unique case (state)
        IDLE: begin
          if (in_valid && in_ready) begin
            shreg       <= in_value;
            bcd         <= '0;
            cnt         <= '0;
            ovf_pending <= 64'(in_value) > MAX_SHOWN;
            state       <= SHIFT;
          end
        end
        SHIFT: begin
          {bcd, shreg} <= {bcd_adj[4*DIGITS-2:0], shreg, 1'b0};
          cnt          <= cnt + 1'b1;
          if (cnt == LAST_BIT) state <= UPDATE;
        end
        UPDATE: begin
          for (int unsigned k = 0; k < DIGITS; k++) seg_q[k] <= seg_d[k];
          ovf_q    <= ovf_pending;
          toggle_q <= ~toggle_q;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready = (state == IDLE) && !SW[1];
  assign LEDR     = {hold_q, toggle_q, ovf_q, state != IDLE};
  assign HEX0     = seg_q[0];
  assign HEX1     = seg_q[1];
  assign HEX2     = seg_q[2];
  assign HEX3     = seg_q[3];
  assign HEX4     = seg_q[4];
  assign HEX5     = seg_q[5];

endmodule

// File: tb/tb_tsp_result_display.sv
// Scoreboard bench for tsp_result_display: directed values with hand-computed
// segment patterns; a negedge monitor checks each display update as it appears.
module tb_tsp_result_display;

  localparam int W = 20;

  logic         clk = 1'b0;
  logic         rst;
  logic [1:0]   SW;
  logic [W-1:0] in_value;
  logic         in_valid;
  logic         in_ready;
  logic [3:0]   LEDR;
  logic [6:0]   HEX0, HEX1, HEX2, HEX3, HEX4, HEX5;
  logic [41:0]  hex_all;

  tsp_result_display #(.W(W), .DIGITS(6)) dut (
    .clk(clk), .rst(rst), .SW(SW), .in_value(in_value), .in_valid(in_valid),
    .in_ready(in_ready), .LEDR(LEDR),
    .HEX0(HEX0), .HEX1(HEX1), .HEX2(HEX2), .HEX3(HEX3), .HEX4(HEX4), .HEX5(HEX5)
  );

  assign hex_all = {HEX5, HEX4, HEX3, HEX2, HEX1, HEX0};

  always #5 clk = ~clk;

  int   cyc = 0;
  logic rst_q = 1'b1;
  always @(posedge clk) begin
    cyc++;
    rst_q <= rst;
  end

  typedef struct {
    logic [41:0] hex;
    logic        ovf;
    int          acc;
  } exp_t;

  exp_t q[$];
  int compared   = 0;
  int mismatched = 0;

  localparam logic [41:0] ALL_BLANK = {6{7'h7F}};

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: every LEDR[2] toggle is one display update and must match the queue head.
  initial begin
    logic prev;
    exp_t e;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (rst_q) begin
        prev = LEDR[2];
      end else if (LEDR[2] !== prev) begin
        prev = LEDR[2];
        if (q.size() == 0) begin
          compared++;
          mismatched++;
          $display("FAIL unexpected_update: got HEX=%0h expected no update (cycle %0d)", hex_all, cyc);
        end else begin
          e = q.pop_front();
          check("hex", hex_all, e.hex);
          check("ovf_led", LEDR[1], e.ovf);
          check("latency", cyc - e.acc, 22);
          check("idle_after_update", LEDR[0], 1'b0);
        end
      end
    end
  end

  task automatic send(input logic [W-1:0] v, input logic [41:0] h, input logic o,
                      input bit expect_update, input bit keep_valid, output int acc);
    int n;
    @(negedge clk);
    in_value = v;
    in_valid = 1'b1;
    n = 0;
    while (!in_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_ready) begin
      compared++;
      mismatched++;
      $display("FAIL accept_timeout: got in_ready=0 expected 1 within 100 cycles");
      in_valid = 1'b0;
      acc = -1;
      return;
    end
    acc = cyc;
    if (expect_update) q.push_back('{hex: h, ovf: o, acc: cyc});
    @(posedge clk);
    #1;
    if (!keep_valid) in_valid = 1'b0;
    check("busy_after_accept", LEDR[0], 1'b1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (q.size() != 0) begin
      compared++;
      mismatched++;
      $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
      q.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0, a1, a2;
    rst      = 1'b1;
    SW       = 2'b00;
    in_value = 20'd5;
    in_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("rst_hex", hex_all, ALL_BLANK);
    check("rst_ledr", LEDR, 4'b0000);
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
    check("ready_after_rst", in_ready, 1'b1);
    @(posedge clk);
    #1;
    check("no_accept_in_rst", LEDR[0], 1'b0);

    send(20'd123456, {7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02}, 1'b0, 1, 0, a0);
    drain();
    check("toggle_after_first", LEDR[2], 1'b1);

    SW = 2'b01;
    send(20'd42,     {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h19, 7'h24}, 1'b0, 1, 0, a0);
    drain();
    send(20'd0,      {7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h7F, 7'h40}, 1'b0, 1, 0, a0);
    drain();
    send(20'd100005, {7'h79, 7'h40, 7'h40, 7'h40, 7'h40, 7'h12}, 1'b0, 1, 0, a0);
    drain();
    send(20'd1000000, {6{7'h3F}}, 1'b1, 1, 0, a0);
    drain();
    send(20'd1048575, {6{7'h3F}}, 1'b1, 1, 0, a0);
    drain();
    send(20'd999999,  {6{7'h10}}, 1'b0, 1, 0, a0);
    drain();

    SW = 2'b00;
    send(20'd0, {6{7'h40}}, 1'b0, 1, 0, a0);
    drain();

    // Hold raised mid-conversion: the in-flight result still lands, nothing new is taken.
    send(20'd314159, {7'h30, 7'h79, 7'h19, 7'h79, 7'h12, 7'h10}, 1'b0, 1, 0, a0);
    repeat (5) @(negedge clk);
    SW       = 2'b10;
    in_value = 20'd555555;
    in_valid = 1'b1;
    repeat (40) @(negedge clk);
    check("hold_ready", in_ready, 1'b0);
    check("hold_led", LEDR[3], 1'b1);
    check("hold_idle", LEDR[0], 1'b0);
    check("hold_hex", hex_all, {7'h30, 7'h79, 7'h19, 7'h79, 7'h12, 7'h10});
    drain();
    in_valid = 1'b0;
    SW       = 2'b00;
    @(negedge clk);
    @(negedge clk);
    check("hold_led_off", LEDR[3], 1'b0);

    send(20'd11,   {7'h40, 7'h40, 7'h40, 7'h40, 7'h79, 7'h79}, 1'b0, 1, 1, a0);
    send(20'd222,  {7'h40, 7'h40, 7'h40, 7'h24, 7'h24, 7'h24}, 1'b0, 1, 1, a1);
    send(20'd3333, {7'h40, 7'h40, 7'h30, 7'h30, 7'h30, 7'h30}, 1'b0, 1, 0, a2);
    check("b2b_spacing_1", a1 - a0, 22);
    check("b2b_spacing_2", a2 - a1, 22);
    drain();

    // Reset lands on e10 of a conversion; that value must never reach the display.
    send(20'd777777, '0, 1'b0, 0, 0, a0);
    repeat (9) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    check("midrst_hex", hex_all, ALL_BLANK);
    check("midrst_ledr", LEDR, 4'b0000);
    rst = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_no_update", hex_all, ALL_BLANK);

    SW = 2'b01;
    send(20'd2024, {7'h7F, 7'h7F, 7'h24, 7'h40, 7'h24, 7'h19}, 1'b0, 1, 0, a0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/tsp_result_display.md
# tsp_result_display

Sink-side display controller for the TSP solver top level. It accepts a binary result (tour cost or iteration count) from the solver over a valid/ready handshake. It converts the result to six BCD digits with a sequential shift-and-add-3 (double-dabble) engine and drives the six active-low seven-segment outputs and status LEDs of the board. It owns the HEX0–HEX5/LEDR pins, so the solver core only produces numbers.

## Interface
- W, 20, width of the binary input value
- DIGITS, 6, number of displayed decimal digits; fixed at 6 for this board
- clk  input  1  system clock; single clock domain
- rst  input  1  reset; synchronous and active-high
- SW  input  2  SW[0]: leading-zero blanking enable; SW[1]: hold (freeze display, refuse new input)
- in_value  input  W  binary result from solver
- in_valid  input  1  in_value is valid
- in_ready  output  1  block can accept; = (state==IDLE) && !SW[1]
- LEDR  output  4  [0] busy, [1] overflow of displayed value, [2] update toggle, [3] hold active
- HEX0..HEX5  output  7 each  active-low segments, bit order {g,f,e,d,c,b,a}; HEX0 = least significant digit

## Operation
- FSM states: IDLE, SHIFT, UPDATE.
- IDLE:
  - in_ready high unless SW[1]=1.
  - On clk edge with in_valid && in_ready: load shift register ← in_value, BCD register (24 bits) ← 0, bit counter ← 0, ovf_pending ← (in_value > 999999); go to SHIFT.
- SHIFT, one input bit per cycle:
  - Every BCD nibble ≥5 gets +3.
  - Then {bcd, shreg} shifts left by 1, so the MSB of shreg enters bcd[0].
  - Counter increments; after W shifts go to UPDATE.
- UPDATE, one cycle:
  - Register the HEX outputs from BCD, ovf_pending and SW[0] sampled on this edge.
  - LEDR[1] ← ovf_pending.
  - LEDR[2] toggles.
  - Return to IDLE.
- Segment codes (hex):
  - Digits: 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78, 8=00, 9=10.
  - blank=7F, dash=3F.
- Overflow: if ovf_pending, all six digits show dash regardless of SW[0].
- Blanking (SW[0]=1): digits above the most significant nonzero digit show 7F. HEX0 is never blanked, so value 0 shows "0".
- LEDR[0] = (state != IDLE). LEDR[3] = SW[1], registered.
- Hold (SW[1]=1):
  - Only blocks new acceptance.
  - A conversion already in SHIFT completes and updates the display.
- in_value is sampled only on the acceptance edge. Later changes while busy are ignored.

## Timing
- Acceptance on edge e0.
- SHIFT occupies edges e1..eW (e1..e20 for W=20).
- HEX/LEDR update on edge eW+1 (e21).
- IDLE re-entered after eW+1, so the earliest next acceptance is eW+2. Back-to-back throughput is one result per W+2 cycles.
- in_ready is combinational from registered state and SW[1]. There is no registered ready delay.
- Reset values, applied on any edge with rst=1 (including mid-SHIFT, which aborts the conversion and discards the value):
  - state=IDLE
  - HEX0..HEX5=7F (all blank)
  - LEDR=4'b0000
  - BCD/shreg/counter=0
  - in_ready=1 when rst=0 and SW[1]=0
- in_valid asserted during rst is not accepted.
- SW is asynchronous to the solver's logic but synchronous to clk in this design. No debounce is done here.

## Test plan
- Reset: assert rst 3 cycles with in_valid=1 → HEX0..5=7F, LEDR=0, no acceptance; in_ready=1 the cycle after release.
- Convert 123456, SW=00: accept at e0 → HEX5..HEX0 = 79,24,30,19,12,02 exactly at e21; LEDR[0]=1 during e1..e21, LEDR[2]=1 after.
- Blanking, SW=01:
  - 42 → HEX5..HEX2=7F, HEX1=19, HEX0=24.
  - 0 → HEX5..HEX1=7F, HEX0=40.
  - 100005 → no blanking of interior zeros: 79,40,40,40,40,12.
- Overflow: 1000000 and 1048575 → all HEX=3F, LEDR[1]=1; then 999999 → all 10, LEDR[1]=0.
- Hold and back-to-back:
  - SW[1]=1 with in_valid high → in_ready=0, display unchanged, LEDR[3]=1.
  - Set SW[1]=1 mid-conversion → that result still displays.
  - Continuous in_valid → acceptances exactly 22 cycles apart; LEDR[2] toggles per update.
- Reset mid-SHIFT: accept 777777, assert rst at e10 → HEX all 7F, no update at e21; the next accepted value converts correctly.
